clock_divider_prog: RTL
=======================

// Module: clock_divider_prog
// PURPOSE
//  Runtime-programmable clock-enable/divided-clock generator for SpaceWire debug and link-rate logic.
//  Generates clk_div with independently programmable high/low phase lengths and rise/fall ticks.
//  Config changes are glitch-free; they take effect only on a period boundary.
//  Periods are exact: high + low cycles, with no extra boundary cycle.
// PARAMETERS
//  CNT_W     11  width of phase counters and cfg_high/cfg_low
//  DEF_HIGH  25  high-phase length (clk cycles) loaded at reset
//  DEF_LOW   25  low-phase length (clk cycles) loaded at reset
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  enable     in   1      run divider; low forces IDLE
//  cfg_high   in   CNT_W  requested high-phase length
//  cfg_low    in   CNT_W  requested low-phase length
//  cfg_valid  in   1      config request; transfer when cfg_valid & cfg_ready
//  cfg_ready  out  1      no config pending
//  clk_div    out  1      divided clock, registered
//  rise_tick  out  1      1-cycle pulse, coincident with first clk_div=1 cycle
//  fall_tick  out  1      1-cycle pulse, coincident with first clk_div=0 cycle of LOW
// BEHAVIOUR
//  Reset values: clk_div=0, rise_tick=0, fall_tick=0, cfg_ready=1, state=IDLE,
//   active cfg = DEF_HIGH/DEF_LOW, pending cleared, counter=0.
//  States: IDLE, HIGH, LOW.
//   IDLE: clk_div=0. When enable=1: next state HIGH, counter=1, clk_div=1, rise_tick=1.
//   HIGH: if counter==act_high: go to LOW, counter=1, clk_div=0, fall_tick=1; else counter++.
//   LOW: if counter==act_low (boundary): apply pending if any, go to HIGH, counter=1, rise_tick=1;
//    else counter++.
//  enable=0 in any state: next cycle IDLE, clk_div=0, no tick; pending config is applied immediately.
//  Zero clamp: a value of 0 in cfg_high/cfg_low (or a DEF_*) is stored as 1.
//   Minimum period is 2 cycles.
//  Handshake: capture into pending on cfg_valid&cfg_ready; cfg_ready=0 from the next cycle until apply.
//   In IDLE, pending is applied the cycle after capture.
//   If capture happens in the same cycle as a LOW boundary, the new config applies at the next boundary.
//  cfg_valid while cfg_ready=0 is ignored; there is no queueing.
//  Reset mid-period aborts it and takes the outputs to reset values on the next edge.
//  Counter never wraps; max phase is 2^CNT_W-1.
// CONFIGURATION
//  CLKDIV_PERIOD_CNT_EN defined:
//   adds output period_cnt [15:0], reset 0, +1 on each rise_tick, wraps 0xFFFF->0.
//  Not defined: port absent and no counter logic.
// STRUCTURE
//  Package clkdiv_pkg:
//   state enum {IDLE,HIGH,LOW}
//   CLKDIV_CNT_W_DEF=11
//   period counter width constant 16
//  Sub-module clkdiv_cfg_shadow: pending/active registers, zero clamp, cfg_ready, apply strobe.
//  The top level holds the FSM, counter and tick generation.
// TESTING
//  1. reset then enable=1 with defaults
//     -> clk_div high 25 cycles, low 25 cycles, period exactly 50; rise_tick every 50 cycles.
//  2. Mid-HIGH, cfg_high=3 cfg_low=2 with valid
//     -> cfg_ready=0; current 25/25 period completes; then period 5 (3 high/2 low); cfg_ready=1 at apply.
//  3. cfg_high=0 cfg_low=0
//     -> clamped to 1/1; clk_div toggles every cycle; rise_tick and fall_tick alternate.
//  4. enable dropped on cycle 10 of HIGH
//     -> clk_div=0 next cycle, no fall_tick.
//     Re-enable -> full 25-cycle HIGH restarts with rise_tick.
//  5. cfg_valid on the exact LOW boundary cycle -> old config used for the following period, new one after.
//     A second cfg_valid while cfg_ready=0 is ignored.
//  6. reset asserted mid-LOW -> all outputs at reset values next edge; DEF config restored.
//     With CLKDIV_PERIOD_CNT_EN, period_cnt=0, and counts to 3 after 3 periods.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
// Used by clock_divider_prog, its config interface and its config shadow.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_CNT_W_DEF = 11;
  localparam int unsigned CLKDIV_PCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } clkdiv_state_e;

  // A zero phase length would stall the divider, so it is treated as one cycle.
  function automatic int unsigned clamp_nz(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/clock_divider_prog_if.sv
// Configuration request channel for clock_divider_prog: new phase lengths
// offered with cfg_valid and accepted while cfg_ready is high.
interface clock_divider_prog_if #(
  parameter int unsigned CNT_W = clkdiv_pkg::CLKDIV_CNT_W_DEF
);

  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (
    output cfg_high,
    output cfg_low,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_high,
    input  cfg_low,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/clkdiv_cfg_shadow.sv
// Pending/active phase-length registers for clock_divider_prog: captures one
// request at a time, clamps zeros to one, and swaps it in on an apply window.
module clkdiv_cfg_shadow
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = CLKDIV_CNT_W_DEF,
  parameter int unsigned DEF_HIGH = 25,
  parameter int unsigned DEF_LOW  = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic [CNT_W-1:0] cfg_low_i,
  input  logic             cfg_valid_i,
  input  logic             apply_ok_i,
  output logic             cfg_ready_o,
  output logic [CNT_W-1:0] act_high_o,
  output logic [CNT_W-1:0] act_low_o
);

  localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(clamp_nz(DEF_HIGH));
  localparam logic [CNT_W-1:0] DEF_LOW_C  = CNT_W'(clamp_nz(DEF_LOW));
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] act_low_q, act_low_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic [CNT_W-1:0] pend_low_q, pend_low_d;
  logic             pend_valid_q, pend_valid_d;
  logic             capture;
  logic             apply;

  // Capture needs an empty slot and apply needs a full one, so they never coincide.
  assign capture = cfg_valid_i && !pend_valid_q;
  assign apply   = pend_valid_q && apply_ok_i;

  always_comb begin
    // NOTE: every _d starts from its held value, so no path leaves it unassigned (no latch).
    act_high_d   = act_high_q;
    act_low_d    = act_low_q;
    pend_high_d  = pend_high_q;
    pend_low_d   = pend_low_q;
    pend_valid_d = pend_valid_q;
    if (capture) begin
      pend_valid_d = 1'b1;
      pend_high_d  = (cfg_high_i == '0) ? ONE_C : cfg_high_i;
      pend_low_d   = (cfg_low_i == '0) ? ONE_C : cfg_low_i;
    end
    if (apply) begin
      pend_valid_d = 1'b0;
      act_high_d   = pend_high_q;
      act_low_d    = pend_low_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_high_q   <= DEF_HIGH_C;
      act_low_q    <= DEF_LOW_C;
      pend_high_q  <= '0;
      pend_low_q   <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      act_high_q   <= act_high_d;
      act_low_q    <= act_low_d;
      pend_high_q  <= pend_high_d;
      pend_low_q   <= pend_low_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign cfg_ready_o = !pend_valid_q;
  assign act_high_o  = act_high_q;
  assign act_low_o   = act_low_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable divided clock with rise/fall ticks and exact high+low periods.
// Optional macro CLKDIV_PERIOD_CNT_EN adds a 16-bit wrapping period counter output.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = CLKDIV_CNT_W_DEF,
  parameter int unsigned DEF_HIGH = 25,
  parameter int unsigned DEF_LOW  = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  clock_divider_prog_if.slave      cfg,
  output logic                     clk_div,
  output logic                     rise_tick,
  output logic                     fall_tick
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [CLKDIV_PCNT_W-1:0] period_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  clkdiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_div_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] act_low;
  logic             cfg_ready_w;
  logic             high_done;
  logic             low_done;
  logic             apply_ok;

  assign high_done = (cnt_q == act_high);
  assign low_done  = (cnt_q == act_low);

  // New phase lengths may only land where no phase is running or one is about to start.
  assign apply_ok = !enable || (state_q == IDLE) || ((state_q == LOW) && low_done);

  clkdiv_cfg_shadow #(
    .CNT_W    (CNT_W),
    .DEF_HIGH (DEF_HIGH),
    .DEF_LOW  (DEF_LOW)
  ) u_cfg_shadow (
    .clk         (clk),
    .reset       (reset),
    .cfg_high_i  (cfg.cfg_high),
    .cfg_low_i   (cfg.cfg_low),
    .cfg_valid_i (cfg.cfg_valid),
    .apply_ok_i  (apply_ok),
    .cfg_ready_o (cfg_ready_w),
    .act_high_o  (act_high),
    .act_low_o   (act_low)
  );

  assign cfg.cfg_ready = cfg_ready_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!enable) begin
        // Disable wins over any phase transition and never emits a tick.
        state_q   <= IDLE;
        cnt_q     <= '0;
        clk_div_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= HIGH;
            cnt_q     <= ONE_C;
            clk_div_q <= 1'b1;
            rise_q    <= 1'b1;
          end
          HIGH: begin
            if (high_done) begin
              state_q   <= LOW;
              cnt_q     <= ONE_C;
              clk_div_q <= 1'b0;
              fall_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end
          LOW: begin
            if (low_done) begin
              state_q   <= HIGH;
              cnt_q     <= ONE_C;
              clk_div_q <= 1'b1;
              rise_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clk_div   = clk_div_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [CLKDIV_PCNT_W-1:0] period_cnt_q;

  // Counts rise ticks already issued; wraps naturally at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_q <= '0;
    end else if (rise_q) begin
      period_cnt_q <= period_cnt_q + CLKDIV_PCNT_W'(1);
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule
